fwd_hazard_scoreboard: RTL and testbench
========================================

# fwd_hazard_scoreboard

Parametrised successor to the two-stage forwarding unit. It keeps its own shadow pipeline of destination tags (Rd, RegWrite, result-ready stage) for instructions issued from ID, so EX-stage mux selects come from internal state rather than MEM/WB taps. It detects load-use style hazards at ID and raises a stall. It also supports any number of source operands, any pipeline depth, per-instruction result latency and a saturating stall counter. It sits beside the ID/EX pipeline register and drives the EX operand muxes and the IF/ID hold logic.

## Interface
- ADDR_W, 5, register address width
- NUM_SRC, 2, source operands per instruction
- DEPTH, 3, tracked stages after ID: index 0 = EX … DEPTH-1 = WB; DEPTH ≥ 2
- CNT_W, 16, stall counter width
- SEL_W, derived = $clog2(DEPTH), forward-select width
- clk_i  in  1  clock
- rst_i  in  1  reset; **one clock; reset is synchronous and active-high**
- ID_valid_i  in  1  valid instruction in ID
- ID_Rs_i  in  NUM_SRC*ADDR_W  source registers; operand s at bits [s*ADDR_W +: ADDR_W]
- ID_Rs_used_i  in  NUM_SRC  per-operand "source actually read"
- ID_RegWrite_i  in  1  instruction writes Rd
- ID_Rd_i  in  ADDR_W  destination register
- ID_Ready_i  in  SEL_W  first stage index whose output holds a forwardable result (ALU = 1, load = 2); legal range 1..DEPTH-1
- Flush_i  in  1  squash the ID instruction
- Stall_o  out  1  hold IF/ID, insert bubble into EX (combinational)
- EX_Fwd_o  out  NUM_SRC*SEL_W  per-operand select for the instruction now in EX; 0 = register file, k = stage k output (registered)
- Stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- State: DEPTH entries {valid, rd, regwrite, ready}, entry[k] = instruction at stage k.
- Match(s, k): entry[k].valid && regwrite && rd != 0 && rd == Rs[s] && ID_Rs_used_i[s].
  - Only the youngest match counts, i.e. the smallest k in 0..DEPTH-2.
  - Entry DEPTH-1 is retiring. The register file is write-through, so this entry is ignored.
- Hazard(s): youngest match at k with entry[k].ready > k+1.
- Stall_o = ID_valid_i && !Flush_i && OR over s of Hazard(s).
- Next select(s): youngest match at k with no hazard gives k+1; no match gives 0.
- Every cycle, entries shift: entry[k+1] ← entry[k], and the oldest entry drops off.
- entry[0] ← ID fields when ID_valid_i && !Stall_o && !Flush_i. Otherwise entry[0] is an invalid bubble.
- EX_Fwd_o ← next select when an instruction is inserted. Otherwise EX_Fwd_o ← 0.
- Stall_cnt_o increments on every cycle with Stall_o = 1 and saturates at all-ones.
- Rs or Rd = x0 never matches, so it never stalls or forwards.

## Timing
- Reset (rst_i sampled high on a clk_i edge) sets:
  - all entries invalid
  - EX_Fwd_o = 0
  - Stall_cnt_o = 0
  - Stall_o = 0 on the following cycle, since there are no valid entries
- Stall_o is valid in the same cycle as the ID inputs.
- EX_Fwd_o is valid one cycle later, while the instruction is in EX.
- A stall lasts until the producer reaches stage ready-1:
  - with DEPTH=3 and ready=2, one cycle
  - with a generic producer, ready-1-k cycles
  - shifting continues during stalls, so the producer keeps advancing
- Flush_i and a hazard in the same cycle: Flush_i wins. Stall_o = 0, a bubble is inserted and the counter does not increment.
- Reset is asserted mid-stream: every in-flight entry is discarded. The first instruction after reset never stalls.
- Several sources hit the same producer: one shared stall, then the same select for each source.

## Structure
- Shared package fwd_pkg holds:
  - the tag-entry struct {valid, rd, regwrite, ready}
  - FWD_SEL_RF = 0
  - the default latency constants READY_ALU = 1 and READY_LOAD = 2
- One natural sub-module, fwd_src_lookup, instantiated NUM_SRC times.
  - It is a youngest-match priority search over entries 0..DEPTH-2.
  - It returns {hit, k, hazard}.
  - Shift register, stall logic and counter live in the top.

## Test plan
- Reset check: hold rst_i 2 cycles, then idle. Stall_o=0, EX_Fwd_o=0, Stall_cnt_o=0.
- ALU chain:
  - issue x5 with ready=1
  - next cycle issue rs1=x5 (used)
  - required: no stall, and EX_Fwd_o[src0]=1 the following cycle
- Load-use:
  - issue x6 with ready=2
  - next cycle issue rs2=x6
  - required: Stall_o=1 for exactly 1 cycle, then EX_Fwd_o[src1]=2, Stall_cnt_o=1
- Youngest wins:
  - write x7 (ready=1) twice back-to-back
  - then consume x7 as rs1
  - required: EX_Fwd_o[src0]=1, not 2
- x0 and unused sources:
  - a load writes x0, then a consumer reads rs1=x0
  - separately, a load writes x8, then a consumer has rs2=x8 with ID_Rs_used_i[1]=0
  - required: no stall and select 0 in both cases
- Flush over hazard:
  - load x9, then a consumer of x9 with Flush_i=1
  - required: Stall_o=0, counter unchanged, next EX_Fwd_o=0

Source files
------------

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared tag-entry type and select/latency constants for the forwarding scoreboard.
// Tag fields are sized to fixed maxima so one struct serves every parametrisation;
// instances zero-extend their narrower register addresses and ready stages into it.
package fwd_pkg;

    localparam int TAG_ADDR_W = 8;
    localparam int TAG_SEL_W  = 8;

    localparam int FWD_SEL_RF = 0;
    localparam int READY_ALU  = 1;
    localparam int READY_LOAD = 2;

    typedef struct packed {
        logic                  valid;
        logic [TAG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic [TAG_SEL_W-1:0]  ready;
    } tag_t;

endpackage

// File: rtl/fwd_src_lookup.sv
// fwd_src_lookup: youngest-match search of one source operand against the shadow pipeline.
// Ports:
//   ent    - tag entries, index 0 = EX .. DEPTH-1 = WB
//   rs     - source register of this operand
//   used   - operand is actually read
//   hit    - some non-retiring producer writes rs
//   k      - stage index of the youngest such producer
//   hazard - that producer's result is not yet forwardable
module fwd_src_lookup
    import fwd_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = $clog2(DEPTH)
) (
    input  tag_t              ent [DEPTH],
    input  logic [ADDR_W-1:0] rs,
    input  logic              used,
    output logic              hit,
    output logic [SEL_W-1:0]  k,
    output logic              hazard
);

    // Scan oldest to youngest so the smallest matching index is the one left standing.
    // The retiring entry is skipped because the register file writes through.
    always_comb begin
        hit    = 1'b0;
        k      = '0;
        hazard = 1'b0;
        for (int j = DEPTH - 2; j >= 0; j--) begin
            if (used && rs != '0 && ent[j].valid && ent[j].regwrite &&
                ent[j].rd == TAG_ADDR_W'(rs)) begin
                hit    = 1'b1;
                k      = SEL_W'(j);
                hazard = int'(ent[j].ready) > j + 1;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard: shadow destination-tag pipeline driving EX forward selects and ID stalls.
// Ports:
//   clk_i, rst_i      - clock, synchronous active-high reset
//   ID_valid_i        - valid instruction in ID
//   ID_Rs_i           - packed source registers, operand s at [s*ADDR_W +: ADDR_W]
//   ID_Rs_used_i      - per-operand source-read flags
//   ID_RegWrite_i     - instruction writes Rd
//   ID_Rd_i           - destination register
//   ID_Ready_i        - first stage whose output holds a forwardable result
//   Flush_i           - squash the ID instruction
//   Stall_o           - hold IF/ID and bubble EX (combinational)
//   EX_Fwd_o          - per-operand forward select for the instruction in EX (registered)
//   Stall_cnt_o       - saturating count of stall cycles
module fwd_hazard_scoreboard
    import fwd_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int CNT_W   = 16,
    parameter int SEL_W   = $clog2(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ID_valid_i,
    input  logic [NUM_SRC*ADDR_W-1:0] ID_Rs_i,
    input  logic [NUM_SRC-1:0]        ID_Rs_used_i,
    input  logic                      ID_RegWrite_i,
    input  logic [ADDR_W-1:0]         ID_Rd_i,
    input  logic [SEL_W-1:0]          ID_Ready_i,
    input  logic                      Flush_i,
    output logic                      Stall_o,
    output logic [NUM_SRC*SEL_W-1:0]  EX_Fwd_o,
    output logic [CNT_W-1:0]          Stall_cnt_o
);

    tag_t                     ent [DEPTH];
    tag_t                     id_tag;
    logic [NUM_SRC-1:0]       hit;
    logic [NUM_SRC-1:0]       haz;
    logic [SEL_W-1:0]         k [NUM_SRC];
    logic [NUM_SRC*SEL_W-1:0] nxt_sel;
    logic                     ins;

    genvar s;
    generate
        for (s = 0; s < NUM_SRC; s++) begin : g_src
            fwd_src_lookup #(
                .ADDR_W(ADDR_W),
                .DEPTH (DEPTH),
                .SEL_W (SEL_W)
            ) u_lookup (
                .ent   (ent),
                .rs    (ID_Rs_i[s*ADDR_W +: ADDR_W]),
                .used  (ID_Rs_used_i[s]),
                .hit   (hit[s]),
                .k     (k[s]),
                .hazard(haz[s])
            );
            // A producer at stage k is seen next cycle as the output of stage k+1.
            assign nxt_sel[s*SEL_W +: SEL_W] = hit[s] ? k[s] + SEL_W'(1) : SEL_W'(FWD_SEL_RF);
        end
    endgenerate

    assign Stall_o = ID_valid_i && !Flush_i && |haz;
    assign ins     = ID_valid_i && !Flush_i && !Stall_o;
    assign id_tag  = '{valid: ins, rd: TAG_ADDR_W'(ID_Rd_i), regwrite: ID_RegWrite_i,
                       ready: TAG_SEL_W'(ID_Ready_i)};

    // Entries keep shifting during a stall so the blocking producer advances.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int j = 0; j < DEPTH; j++) ent[j] <= '0;
            EX_Fwd_o    <= '0;
            Stall_cnt_o <= '0;
        end else begin
            ent[0] <= id_tag;
            for (int j = 1; j < DEPTH; j++) ent[j] <= ent[j-1];
            EX_Fwd_o    <= ins ? nxt_sel : '0;
            Stall_cnt_o <= Stall_cnt_o + CNT_W'(Stall_o && !(&Stall_cnt_o));
        end
    end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// tb_fwd_hazard_scoreboard: directed vector bench for the forwarding scoreboard.
module tb_fwd_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_valid = 0, a_rw = 0, a_flush = 0;
    logic [9:0]  a_rs = '0;
    logic [1:0]  a_used = '0, a_rdy = '0;
    logic [4:0]  a_rd = '0;
    logic        a_stall;
    logic [3:0]  a_fwd;
    logic [15:0] a_cnt;

    logic        b_valid = 0, b_rw = 0, b_flush = 0;
    logic [9:0]  b_rs = '0;
    logic [1:0]  b_used = '0, b_rdy = '0;
    logic [4:0]  b_rd = '0;
    logic        b_stall;
    logic [3:0]  b_fwd;
    logic [1:0]  b_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fwd_hazard_scoreboard #(.ADDR_W(5), .NUM_SRC(2), .DEPTH(3), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .ID_valid_i(a_valid), .ID_Rs_i(a_rs),
        .ID_Rs_used_i(a_used), .ID_RegWrite_i(a_rw), .ID_Rd_i(a_rd),
        .ID_Ready_i(a_rdy), .Flush_i(a_flush), .Stall_o(a_stall),
        .EX_Fwd_o(a_fwd), .Stall_cnt_o(a_cnt)
    );

    fwd_hazard_scoreboard #(.ADDR_W(5), .NUM_SRC(2), .DEPTH(4), .CNT_W(2)) dut4 (
        .clk_i(clk), .rst_i(rst), .ID_valid_i(b_valid), .ID_Rs_i(b_rs),
        .ID_Rs_used_i(b_used), .ID_RegWrite_i(b_rw), .ID_Rd_i(b_rd),
        .ID_Ready_i(b_rdy), .Flush_i(b_flush), .Stall_o(b_stall),
        .EX_Fwd_o(b_fwd), .Stall_cnt_o(b_cnt)
    );

    typedef struct {
        logic        va;
        logic [4:0]  r0, r1;
        logic [1:0]  u;
        logic        w;
        logic [4:0]  d;
        logic [1:0]  rdy;
        logic        fl;
        logic        st;
        logic [1:0]  f0, f1;
        logic [15:0] c;
    } vec_t;

    vec_t tv [24];

    function automatic vec_t v(input logic va, input logic [4:0] r0, input logic [4:0] r1,
                               input logic [1:0] u, input logic w, input logic [4:0] d,
                               input logic [1:0] rdy, input logic fl, input logic st,
                               input logic [1:0] f0, input logic [1:0] f1, input logic [15:0] c);
        return '{va, r0, r1, u, w, d, rdy, fl, st, f0, f1, c};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic va, input logic [4:0] r0, input logic [4:0] r1,
                           input logic [1:0] u, input logic w, input logic [4:0] d,
                           input logic [1:0] rdy, input logic fl);
        a_valid = va; a_rs = {r1, r0}; a_used = u; a_rw = w; a_rd = d; a_rdy = rdy; a_flush = fl;
    endtask

    task automatic drive_b(input logic va, input logic [4:0] r0, input logic [1:0] u,
                           input logic w, input logic [4:0] d, input logic [1:0] rdy);
        b_valid = va; b_rs = {5'd0, r0}; b_used = u; b_rw = w; b_rd = d; b_rdy = rdy; b_flush = 0;
    endtask

    initial begin
        //        va r0  r1  u  w  d   rdy fl | st f0 f1 cnt
        tv[0]  = v(0, 0,  0,  0, 0, 0,  0, 0,   0, 0, 0, 0);
        tv[1]  = v(1, 0,  0,  0, 1, 5,  1, 0,   0, 0, 0, 0);
        tv[2]  = v(1, 5,  0,  1, 0, 0,  0, 0,   0, 0, 0, 0);
        tv[3]  = v(0, 0,  0,  0, 0, 0,  0, 0,   0, 1, 0, 0);
        tv[4]  = v(1, 0,  0,  0, 1, 6,  2, 0,   0, 0, 0, 0);
        tv[5]  = v(1, 0,  6,  2, 0, 0,  0, 0,   1, 0, 0, 0);
        tv[6]  = v(1, 0,  6,  2, 0, 0,  0, 0,   0, 0, 0, 1);
        tv[7]  = v(0, 0,  0,  0, 0, 0,  0, 0,   0, 0, 2, 1);
        tv[8]  = v(1, 0,  0,  0, 1, 7,  1, 0,   0, 0, 0, 1);
        tv[9]  = v(1, 0,  0,  0, 1, 7,  1, 0,   0, 0, 0, 1);
        tv[10] = v(1, 7,  0,  1, 0, 0,  0, 0,   0, 0, 0, 1);
        tv[11] = v(0, 0,  0,  0, 0, 0,  0, 0,   0, 1, 0, 1);
        tv[12] = v(1, 0,  0,  0, 1, 0,  2, 0,   0, 0, 0, 1);
        tv[13] = v(1, 0,  0,  1, 0, 0,  0, 0,   0, 0, 0, 1);
        tv[14] = v(1, 0,  0,  0, 1, 8,  2, 0,   0, 0, 0, 1);
        tv[15] = v(1, 0,  8,  0, 0, 0,  0, 0,   0, 0, 0, 1);
        tv[16] = v(0, 0,  0,  0, 0, 0,  0, 0,   0, 0, 0, 1);
        tv[17] = v(1, 0,  0,  0, 1, 9,  2, 0,   0, 0, 0, 1);
        tv[18] = v(1, 9,  0,  1, 0, 0,  0, 1,   0, 0, 0, 1);
        tv[19] = v(0, 0,  0,  0, 0, 0,  0, 0,   0, 0, 0, 1);
        tv[20] = v(1, 0,  0,  0, 1, 10, 2, 0,   0, 0, 0, 1);
        tv[21] = v(1, 10, 10, 3, 0, 0,  0, 0,   1, 0, 0, 1);
        tv[22] = v(1, 10, 10, 3, 0, 0,  0, 0,   0, 0, 0, 2);
        tv[23] = v(0, 0,  0,  0, 0, 0,  0, 0,   0, 2, 2, 2);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            drive_a(tv[i].va, tv[i].r0, tv[i].r1, tv[i].u, tv[i].w, tv[i].d, tv[i].rdy, tv[i].fl);
            #1;
            chk($sformatf("row%0d_stall", i), 32'(a_stall), 32'(tv[i].st));
            chk($sformatf("row%0d_fwd", i), 32'(a_fwd), 32'({tv[i].f1, tv[i].f0}));
            chk($sformatf("row%0d_cnt", i), 32'(a_cnt), 32'(tv[i].c));
        end

        // DEPTH=4 instance: ready=3 producer stalls twice, then forwards from stage 3;
        // the 2-bit counter must stop at 3 on the second round.
        @(negedge clk); drive_a(0, 0, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 2; r++) begin
            drive_b(1, 0, 0, 1, 3, 3);
            #1; chk($sformatf("d4_r%0d_prod_stall", r), 32'(b_stall), 0);
            @(negedge clk); drive_b(1, 3, 1, 0, 0, 0);
            #1; chk($sformatf("d4_r%0d_stall1", r), 32'(b_stall), 1);
            chk($sformatf("d4_r%0d_cnt1", r), 32'(b_cnt), r == 0 ? 0 : 2);
            @(negedge clk);
            #1; chk($sformatf("d4_r%0d_stall2", r), 32'(b_stall), 1);
            chk($sformatf("d4_r%0d_cnt2", r), 32'(b_cnt), r == 0 ? 1 : 3);
            @(negedge clk);
            #1; chk($sformatf("d4_r%0d_stall3", r), 32'(b_stall), 0);
            chk($sformatf("d4_r%0d_cnt3", r), 32'(b_cnt), r == 0 ? 2 : 3);
            @(negedge clk); drive_b(0, 0, 0, 0, 0, 0);
            #1; chk($sformatf("d4_r%0d_fwd", r), 32'(b_fwd), 32'h3);
            chk($sformatf("d4_r%0d_cnt_idle", r), 32'(b_cnt), r == 0 ? 2 : 3);
            @(negedge clk);
        end

        // Reset in mid-stream discards the in-flight load of x11.
        drive_a(1, 0, 0, 0, 1, 11, 2, 0);
        @(negedge clk); drive_a(0, 0, 0, 0, 0, 0, 0, 0); rst = 1'b1;
        @(negedge clk); rst = 1'b0; drive_a(1, 11, 0, 1, 0, 0, 0, 0);
        #1;
        chk("rst_mid_stall", 32'(a_stall), 0);
        chk("rst_mid_cnt", 32'(a_cnt), 0);
        chk("rst_mid_fwd", 32'(a_fwd), 0);
        @(negedge clk); drive_a(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_mid_fwd_next", 32'(a_fwd), 0);
        chk("rst_mid_cnt_next", 32'(a_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
